// File: rtl/strip_scheduler_pkg.sv
// Shared types and constants for the strip scheduler slice.
package strip_scheduler_pkg;

  // Default filter edge; also the height of one output row-strip.
  localparam int K_DEFAULT = 4;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ADV   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // Error codes reported to the host; held until the next accepted start.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_DIMS  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

endpackage

// File: rtl/strip_scheduler_if.sv
// Host and engine handshake bundle of the strip scheduler.
// master = host/engine side, slave = the scheduler itself.
interface strip_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] img_base;
  logic [ADDR_W-1:0] out_base;
  logic [ADDR_W-1:0] flt_base;
  logic [DIM_W-1:0]  img_w;
  logic [DIM_W-1:0]  img_h;
  logic              eng_done;
  logic              eng_start;
  logic              eng_flt_load;
  logic [ADDR_W-1:0] eng_img_addr;
  logic [ADDR_W-1:0] eng_out_addr;
  logic [ADDR_W-1:0] eng_flt_addr;
  logic [DIM_W-1:0]  strip_idx;
  logic              busy;
  logic              done;
  logic [1:0]        err;

  modport master (
    output start, abort, img_base, out_base, flt_base, img_w, img_h, eng_done,
    input  eng_start, eng_flt_load, eng_img_addr, eng_out_addr, eng_flt_addr,
           strip_idx, busy, done, err
  );

  modport slave (
    input  start, abort, img_base, out_base, flt_base, img_w, img_h, eng_done,
    output eng_start, eng_flt_load, eng_img_addr, eng_out_addr, eng_flt_addr,
           strip_idx, busy, done, err
  );
endinterface

// File: rtl/strip_scheduler_watchdog.sv
// Engine watchdog: cleared while a strip is issued, counts while waiting,
// saturates at all-ones and flags expiry there.
module sched_watchdog #(
  parameter int TMO_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TMO_W-1:0] count_r;

  assign expired = &count_r;

  // Saturating wait counter; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TMO_W{1'b0}};
    end else if (clr) begin
      count_r <= {TMO_W{1'b0}};
    end else if (en && !expired) begin
      count_r <= count_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end
endmodule

// File: rtl/strip_scheduler.sv
// Frame sequencer: runs the filter engine once per output row-strip,
// stepping strip base addresses by accumulation (no multiplier).
module strip_scheduler
  import strip_scheduler_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int K      = K_DEFAULT,
  parameter int TMO_W  = 12
) (
  input logic              clk,
  input logic              rst,
  strip_scheduler_if.slave bus
);
  localparam logic [DIM_W-1:0]  K_DIM    = DIM_W'(K);
  localparam logic [DIM_W-1:0]  ONE_DIM  = DIM_W'(1);
  localparam logic [ADDR_W-1:0] K_M1_ADR = ADDR_W'(K - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] img_base_r, out_base_r, flt_base_r;
  logic [DIM_W-1:0]  img_w_r, img_h_r, y_r;
  logic [ADDR_W-1:0] img_ptr_r, out_ptr_r;
  logic              eng_start_r, eng_flt_load_r, busy_r, done_r;
  logic [1:0]        err_r;
  logic              expired_s;
  logic [ADDR_W-1:0] img_step_s, out_step_s;
  logic [DIM_W-1:0]  last_y_s;
  logic              bad_dims_s;

  // Input rows advance by the frame width, output rows by width-K+1.
  assign img_step_s = {{(ADDR_W-DIM_W){1'b0}}, img_w_r};
  assign out_step_s = img_step_s - K_M1_ADR;
  assign last_y_s   = img_h_r - K_DIM;
  assign bad_dims_s = (img_w_r < K_DIM) || (img_h_r < K_DIM);

  sched_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_r == ST_ISSUE),
    .en      (state_r == ST_WAIT),
    .expired (expired_s)
  );

  // Frame FSM with registered engine/host outputs; abort overrides every busy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      img_base_r     <= {ADDR_W{1'b0}};
      out_base_r     <= {ADDR_W{1'b0}};
      flt_base_r     <= {ADDR_W{1'b0}};
      img_w_r        <= {DIM_W{1'b0}};
      img_h_r        <= {DIM_W{1'b0}};
      y_r            <= {DIM_W{1'b0}};
      img_ptr_r      <= {ADDR_W{1'b0}};
      out_ptr_r      <= {ADDR_W{1'b0}};
      eng_start_r    <= 1'b0;
      eng_flt_load_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= ERR_NONE;
    end else begin
      eng_start_r    <= 1'b0;
      eng_flt_load_r <= 1'b0;
      done_r         <= 1'b0;
      if ((state_r != ST_IDLE) && bus.abort) begin
        err_r   <= ERR_ABORT;
        done_r  <= 1'b1;
        busy_r  <= 1'b0;
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.start) begin
              img_base_r <= bus.img_base;
              out_base_r <= bus.out_base;
              flt_base_r <= bus.flt_base;
              img_w_r    <= bus.img_w;
              img_h_r    <= bus.img_h;
              y_r        <= {DIM_W{1'b0}};
              err_r      <= ERR_NONE;
              busy_r     <= 1'b1;
              state_r    <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (bad_dims_s) begin
              err_r   <= ERR_DIMS;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              // First strip of the frame: the engine loads the filter.
              img_ptr_r      <= img_base_r;
              out_ptr_r      <= out_base_r;
              eng_start_r    <= 1'b1;
              eng_flt_load_r <= 1'b1;
              state_r        <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            state_r <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.eng_done) begin
              state_r <= ST_ADV;
            end else if (expired_s) begin
              err_r   <= ERR_TMO;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          ST_ADV: begin
            if (y_r == last_y_s) begin
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end else begin
              // Later strips reuse the loaded filter.
              y_r         <= y_r + ONE_DIM;
              img_ptr_r   <= img_ptr_r + img_step_s;
              out_ptr_r   <= out_ptr_r + out_step_s;
              eng_start_r <= 1'b1;
              state_r     <= ST_ISSUE;
            end
          end
          ST_FIN: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.eng_start    = eng_start_r;
  assign bus.eng_flt_load = eng_flt_load_r;
  assign bus.eng_img_addr = img_ptr_r;
  assign bus.eng_out_addr = out_ptr_r;
  assign bus.eng_flt_addr = flt_base_r;
  assign bus.strip_idx    = y_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
endmodule

// File: tb/tb_strip_scheduler.sv
// Directed bench for strip_scheduler with an engine responder and an
// expected-strip scoreboard filled when each frame is started.
module tb_strip_scheduler;
  localparam int K     = 4;
  localparam int TMO_W = 4;

  typedef struct {
    logic [15:0] img;
    logic [15:0] out;
    logic        fl;
  } exp_t;

  logic clk;
  logic rst;
  strip_scheduler_if #(.ADDR_W(16), .DIM_W(8)) bus ();

  strip_scheduler #(.ADDR_W(16), .DIM_W(8), .K(K), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   nstarts, start_cyc, first_start_cyc, last_start_cyc;
  int   last_done_cyc, done_cyc, abort_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic all_zero(input string tag);
    check(tag, {bus.eng_start, bus.eng_flt_load, bus.eng_img_addr, bus.eng_out_addr,
                bus.eng_flt_addr, bus.strip_idx, bus.busy, bus.done, bus.err}, 64'd0);
  endtask

  // One frame: drive start, answer eng_start with eng_done 3 cycles later,
  // optionally withhold a done, abort or reset on a given strip.
  task automatic run_frame(input logic [15:0] ib, input logic [15:0] ob, input logic [15:0] fb,
                           input int w, input int h, input int hold_strip, input int abort_strip,
                           input int rst_strip, input bit keep_start, input bit spurious);
    exp_t e, cur;
    int   done_at, abort_at, rst_at;
    bit   fin;
    nstarts = 0; first_start_cyc = -1; last_start_cyc = -1; last_done_cyc = -1;
    done_cyc = -1; abort_cyc = -1; done_at = -1; abort_at = -1; rst_at = -1; fin = 1'b0;
    cur.img = 16'h0; cur.out = 16'h0; cur.fl = 1'b0;
    bus.img_base = ib; bus.out_base = ob; bus.flt_base = fb;
    bus.img_w = 8'(w); bus.img_h = 8'(h); bus.start = 1'b1;
    start_cyc = cyc;
    if (w >= K && h >= K) begin
      for (int y = 0; y <= h - K; y++) begin
        e.img = ib + 16'(y * w);
        e.out = ob + 16'(y * (w - K + 1));
        e.fl  = (y == 0);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < 400 && !fin; i++) begin
      step();
      if (!keep_start) bus.start = 1'b0;
      bus.img_base = 16'hdead; bus.img_w = 8'd1;   // config may change after acceptance
      bus.eng_done = 1'b0; bus.abort = 1'b0;
      if (rst) begin
        all_zero("rst_outputs");
        rst = 1'b0;
        fin = 1'b1;
      end else begin
        if (bus.eng_start) begin
          nstarts++;
          if (first_start_cyc < 0) first_start_cyc = cyc;
          last_start_cyc = cyc;
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("img_addr", bus.eng_img_addr, cur.img);
            check("out_addr", bus.eng_out_addr, cur.out);
            check("flt_load", bus.eng_flt_load, cur.fl);
          end else begin
            check("eng_start_unexp", bus.eng_start, 1'b0);
          end
          check("strip_idx", bus.strip_idx, 64'(nstarts - 1));
          if (spurious && nstarts == 1) bus.eng_done = 1'b1;
          done_at  = (nstarts - 1 == hold_strip) ? -1 : cyc + 3;
          if (nstarts - 1 == abort_strip) abort_at = cyc + 1;
          if (nstarts - 1 == rst_strip) rst_at = cyc + 1;
        end
        if (cyc == done_at) begin
          check("addr_stable", {bus.eng_img_addr, bus.eng_out_addr}, {cur.img, cur.out});
          bus.eng_done = 1'b1;
          last_done_cyc = cyc;
        end
        if (cyc == abort_at) begin
          bus.abort = 1'b1;
          abort_cyc = cyc;
        end
        if (cyc == rst_at) rst = 1'b1;
        if (bus.done) begin
          done_cyc = cyc;
          fin = 1'b1;
        end
      end
    end
    check("frame_bounded", fin, 1'b1);
    bus.start = 1'b0; bus.eng_done = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.eng_done = 1'b0;
    bus.img_base = 16'h0; bus.out_base = 16'h0; bus.flt_base = 16'h0;
    bus.img_w = 8'd0; bus.img_h = 8'd0;
    step(); step();
    all_zero("reset_state");
    rst = 1'b0;
    step();

    // 1: 8x8 frame, five strips
    run_frame(16'h0100, 16'h0800, 16'h0040, 8, 8, -1, -1, -1, 1'b0, 1'b0);
    check("t1_strips", 64'(nstarts), 64'd5);
    check("t1_err", bus.err, 2'b00);
    check("t1_flt_addr", bus.eng_flt_addr, 16'h0040);
    check("t1_start_lat", 64'(first_start_cyc - start_cyc), 64'd2);
    check("t1_done_lat", 64'(done_cyc - last_done_cyc), 64'd2);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);
    step();
    check("t1_busy_low", bus.busy, 1'b0);
    check("t1_done_once", bus.done, 1'b0);

    // 2: minimum 4x4 frame, single strip
    run_frame(16'h2000, 16'h3000, 16'h0010, 4, 4, -1, -1, -1, 1'b0, 1'b0);
    check("t2_strips", 64'(nstarts), 64'd1);
    check("t2_err", bus.err, 2'b00);
    step();

    // 3: width below K
    run_frame(16'h0100, 16'h0800, 16'h0040, 3, 8, -1, -1, -1, 1'b0, 1'b0);
    exp_q.delete();
    check("t3_strips", 64'(nstarts), 64'd0);
    check("t3_err", bus.err, 2'b01);
    check("t3_done_lat", 64'(done_cyc - start_cyc), 64'd2);
    check("t3_busy", bus.busy, 1'b0);
    step();

    // 4: engine never finishes strip 2 -> watchdog
    run_frame(16'h0100, 16'h0800, 16'h0040, 8, 8, 2, -1, -1, 1'b0, 1'b0);
    exp_q.delete();
    check("t4_strips", 64'(nstarts), 64'd3);
    check("t4_err", bus.err, 2'b10);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_tmo_window", ((done_cyc - last_start_cyc) >= (1 << TMO_W)) &&
                           ((done_cyc - last_start_cyc) <= (1 << TMO_W) + 1), 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t4_no_start", bus.eng_start, 1'b0);
    end

    // 5: abort in WAIT of strip 1, then a clean frame
    run_frame(16'h0100, 16'h0800, 16'h0040, 8, 8, -1, 1, -1, 1'b0, 1'b0);
    exp_q.delete();
    check("t5_strips", 64'(nstarts), 64'd2);
    check("t5_err", bus.err, 2'b11);
    check("t5_done_lat", 64'(done_cyc - abort_cyc), 64'd1);
    check("t5_busy", bus.busy, 1'b0);
    step();
    run_frame(16'hfff0, 16'h0500, 16'h0070, 10, 6, -1, -1, -1, 1'b0, 1'b0);
    check("t5b_strips", 64'(nstarts), 64'd3);
    check("t5b_err", bus.err, 2'b00);
    step();

    // 6: start held through the frame plus a spurious eng_done in ISSUE
    run_frame(16'h0400, 16'h0900, 16'h0020, 6, 5, -1, -1, -1, 1'b1, 1'b1);
    check("t6_strips", 64'(nstarts), 64'd2);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);
    step(); step();
    check("t6_idle", bus.busy, 1'b0);

    // 6b: reset mid-WAIT of strip 1
    run_frame(16'h0100, 16'h0800, 16'h0040, 8, 8, -1, -1, 1, 1'b0, 1'b0);
    exp_q.delete();
    check("t6b_no_done", 64'(done_cyc), 64'hffffffff_ffffffff);
    step();
    all_zero("t6b_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
